// File: rtl/pfu_redirect.sv
// -----------------------------------------------------------------------------
// pfu_redirect : instruction prefetch unit with pipelined fetch and redirect.
//
// It issues in-order fetch requests to the instruction cache and keeps up to
// 2**C_OUTST_X of them in flight. A small in-order tag queue remembers the
// address of every request that is still in flight. Responses are stored in a
// 2**C_FIFO_DEPTH_X entry buffer that the decoder reads. A new request is only
// issued when a buffer slot is free for every request already in flight, so
// the buffer can never overflow.
//
// A redirect (hvec_pc_wr_i) does four things: it reloads the PC, flushes the
// buffer, marks every in-flight response as stale so that it is dropped on
// arrival, and tags the next kept entry with SOFID_JUMP.
//
// Ports
//   clk_i, resetb_i        clock, asynchronous active-low reset
//   clk_en_i               clock enable; all state holds while low
//   ireq*                  fetch request channel to the instruction cache
//   irsp*                  in-order fetch response channel from the cache
//   ids_*                  head of the instruction buffer towards the decoder
//   hvec_pc_wr_i/_din_i    redirect strobe and target address
//   exs_hpl_i              current privilege level, forwarded on requests
// -----------------------------------------------------------------------------
module pfu_redirect #(
  parameter int unsigned C_BUS_SZX      = 5,
  parameter int unsigned C_FIFO_DEPTH_X = 2,
  parameter int unsigned C_OUTST_X      = 1,
  parameter int unsigned C_PC_STEP      = 4,
  parameter int unsigned SOFID_SZ       = 2,
  parameter logic [(2**C_BUS_SZX)-1:0] C_RESET_VECTOR = {(2**C_BUS_SZX){1'b0}},
  localparam int unsigned C_BUS_SZ      = 2**C_BUS_SZX
) (
  input  logic                clk_i,
  input  logic                resetb_i,
  input  logic                clk_en_i,
  input  logic                ireqready_i,
  output logic                ireqvalid_o,
  output logic [1:0]          ireqhpl_o,
  output logic [C_BUS_SZ-1:0] ireqaddr_o,
  output logic                irspready_o,
  input  logic                irspvalid_i,
  input  logic                irsprerr_i,
  input  logic [C_BUS_SZ-1:0] irspdata_i,
  output logic                ids_dav_o,
  input  logic                ids_ack_i,
  output logic [SOFID_SZ-1:0] ids_sofid_o,
  output logic [C_BUS_SZ-1:0] ids_ins_o,
  output logic                ids_ferr_o,
  output logic [C_BUS_SZ-1:0] ids_pc_o,
  input  logic                hvec_pc_wr_i,
  input  logic [C_BUS_SZ-1:0] hvec_pc_din_i,
  input  logic [1:0]          exs_hpl_i
);

  localparam int unsigned DEPTH = 2**C_FIFO_DEPTH_X;
  localparam int unsigned OUTST = 2**C_OUTST_X;
  localparam int unsigned FPW   = (C_FIFO_DEPTH_X > 0) ? C_FIFO_DEPTH_X : 1;
  localparam int unsigned TPW   = (C_OUTST_X > 0) ? C_OUTST_X : 1;
  localparam int unsigned FCW   = C_FIFO_DEPTH_X + 1;
  localparam int unsigned OCW   = C_OUTST_X + 1;
  // Wide enough to hold buffer occupancy plus in-flight requests.
  localparam int unsigned UCW   = C_FIFO_DEPTH_X + 2;

  localparam logic [FPW-1:0]      FIFO_LAST  = FPW'(DEPTH - 1);
  localparam logic [TPW-1:0]      TAG_LAST   = TPW'(OUTST - 1);
  localparam logic [SOFID_SZ-1:0] SOFID_RUN  = SOFID_SZ'(0);
  localparam logic [SOFID_SZ-1:0] SOFID_JUMP = SOFID_SZ'(1);

  logic [C_BUS_SZ-1:0] pc_q, pc_d;
  logic [OCW-1:0]      outst_q, outst_d;
  logic [OCW-1:0]      kill_q, kill_d;
  logic [FCW-1:0]      cnt_q, cnt_d;
  logic [FPW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TPW-1:0]      tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [SOFID_SZ-1:0] sofid_q, sofid_d;

  logic [C_BUS_SZ-1:0] tag_mem_q   [OUTST];
  logic [SOFID_SZ-1:0] buf_sofid_q [DEPTH];
  logic                buf_ferr_q  [DEPTH];
  logic [C_BUS_SZ-1:0] buf_pc_q    [DEPTH];
  logic [C_BUS_SZ-1:0] buf_ins_q   [DEPTH];

  logic [UCW-1:0] used_s;
  logic           redirect_s, req_s, accept_s, rsp_s, keep_s, pop_s;

  function automatic logic [FPW-1:0] fifo_next(input logic [FPW-1:0] p);
    logic [FPW-1:0] n;
    if (p == FIFO_LAST) begin
      n = FPW'(0);
    end else begin
      n = p + FPW'(1);
    end
    return n;
  endfunction

  function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
    logic [TPW-1:0] n;
    if (p == TAG_LAST) begin
      n = TPW'(0);
    end else begin
      n = p + TPW'(1);
    end
    return n;
  endfunction

  // Event decode. Every event is qualified by clk_en_i, so while the enable
  // is low each next-state value equals its current value. The request is
  // also withheld then, so that no handshake can complete while the unit is
  // frozen.
  always_comb begin
    redirect_s = clk_en_i & hvec_pc_wr_i;
    used_s     = UCW'(cnt_q) + UCW'(outst_q);
    req_s      = resetb_i & clk_en_i & ~hvec_pc_wr_i
               & (outst_q < OCW'(OUTST)) & (used_s < UCW'(DEPTH));
    accept_s   = req_s & ireqready_i;
    // A response can only arrive for a request that is in flight.
    rsp_s      = clk_en_i & irspvalid_i & (outst_q != OCW'(0));
    keep_s     = rsp_s & ~redirect_s & (kill_q == OCW'(0));
    pop_s      = clk_en_i & ids_ack_i & ~redirect_s & (cnt_q != FCW'(0));
  end

  // Next-state logic for the PC, counters, pointers and sofid state.
  always_comb begin
    pc_d     = pc_q;
    kill_d   = kill_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sofid_d  = sofid_q;
    // The tag queue tracks in-flight requests even across redirects, because
    // stale responses still come back and must be retired in order.
    outst_d  = outst_q + OCW'(accept_s) - OCW'(rsp_s);
    tag_wr_d = accept_s ? tag_next(tag_wr_q) : tag_wr_q;
    tag_rd_d = rsp_s ? tag_next(tag_rd_q) : tag_rd_q;
    if (redirect_s) begin
      pc_d     = hvec_pc_din_i;
      // Everything still in flight after this cycle is stale. The kill count
      // is reloaded here and never added to an older count.
      kill_d   = outst_q - OCW'(rsp_s);
      cnt_d    = FCW'(0);
      wr_ptr_d = FPW'(0);
      rd_ptr_d = FPW'(0);
      sofid_d  = SOFID_JUMP;
    end else begin
      if (accept_s) begin
        pc_d = pc_q + C_BUS_SZ'(C_PC_STEP);
      end else begin
        pc_d = pc_q;
      end
      if (rsp_s && (kill_q != OCW'(0))) begin
        kill_d = kill_q - OCW'(1);
      end else begin
        kill_d = kill_q;
      end
      cnt_d    = cnt_q + FCW'(keep_s) - FCW'(pop_s);
      wr_ptr_d = keep_s ? fifo_next(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s ? fifo_next(rd_ptr_q) : rd_ptr_q;
      sofid_d  = keep_s ? SOFID_RUN : sofid_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      pc_q     <= C_RESET_VECTOR;
      outst_q  <= OCW'(0);
      kill_q   <= OCW'(0);
      cnt_q    <= FCW'(0);
      wr_ptr_q <= FPW'(0);
      rd_ptr_q <= FPW'(0);
      tag_wr_q <= TPW'(0);
      tag_rd_q <= TPW'(0);
      sofid_q  <= SOFID_JUMP;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      sofid_q  <= sofid_d;
    end
  end

  // Tag queue and instruction buffer storage.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int unsigned i = 0; i < OUTST; i++) begin
        tag_mem_q[i] <= {C_BUS_SZ{1'b0}};
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_sofid_q[i] <= SOFID_RUN;
        buf_ferr_q[i]  <= 1'b0;
        buf_pc_q[i]    <= {C_BUS_SZ{1'b0}};
        buf_ins_q[i]   <= {C_BUS_SZ{1'b0}};
      end
    end else begin
      if (accept_s) begin
        tag_mem_q[tag_wr_q] <= pc_q;
      end
      if (keep_s) begin
        buf_sofid_q[wr_ptr_q] <= sofid_q;
        buf_ferr_q[wr_ptr_q]  <= irsprerr_i;
        buf_pc_q[wr_ptr_q]    <= tag_mem_q[tag_rd_q];
        buf_ins_q[wr_ptr_q]   <= irspdata_i;
      end
    end
  end

  assign ireqvalid_o = req_s;
  assign ireqhpl_o   = exs_hpl_i;
  assign ireqaddr_o  = pc_q;
  assign irspready_o = 1'b1;

  // The buffer head is read straight from the storage registers, so a write
  // into an empty buffer is visible one cycle later with no bypass.
  assign ids_dav_o   = (cnt_q != FCW'(0));
  assign ids_sofid_o = buf_sofid_q[rd_ptr_q];
  assign ids_ferr_o  = buf_ferr_q[rd_ptr_q];
  assign ids_pc_o    = buf_pc_q[rd_ptr_q];
  assign ids_ins_o   = buf_ins_q[rd_ptr_q];

endmodule

// File: tb/tb_pfu_redirect.sv
// -----------------------------------------------------------------------------
// tb_pfu_redirect : self-checking bench for pfu_redirect (default parameters).
// A queue-based model (instruction buffer, in-flight request list, stale
// response count) predicts every output; a negedge process compares the DUT
// against it on every cycle. The same in-flight list acts as the cache and
// returns data = addr ^ 0xC0DE0000 after a programmable latency.
// -----------------------------------------------------------------------------
module tb_pfu_redirect;

  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_JUMP = 2'b01;
  localparam int DEPTH = 4;
  localparam int OUTST = 2;

  logic        clk_i = 1'b0;
  logic        resetb_i, clk_en_i, ireqready_i, ireqvalid_o, irspready_o;
  logic [1:0]  ireqhpl_o, exs_hpl_i, ids_sofid_o;
  logic [31:0] ireqaddr_o, irspdata_i, ids_ins_o, ids_pc_o, hvec_pc_din_i;
  logic        irspvalid_i, irsprerr_i, ids_dav_o, ids_ack_i, ids_ferr_o;
  logic        hvec_pc_wr_i;

  typedef struct { logic [1:0] sofid; logic ferr; logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } req_t;

  ent_t        m_buf[$];
  req_t        cq[$];
  int          m_kill, cyc, lat, n_chk, n_fail;
  bit          m_jump, rsp_hold, found;
  logic [31:0] m_pc, err_addr;

  pfu_redirect #(.C_BUS_SZX(5), .C_FIFO_DEPTH_X(2), .C_OUTST_X(1), .C_PC_STEP(4),
                 .SOFID_SZ(2), .C_RESET_VECTOR(32'h0)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .ireqready_i(ireqready_i), .ireqvalid_o(ireqvalid_o), .ireqhpl_o(ireqhpl_o),
    .ireqaddr_o(ireqaddr_o), .irspready_o(irspready_o), .irspvalid_i(irspvalid_i),
    .irsprerr_i(irsprerr_i), .irspdata_i(irspdata_i), .ids_dav_o(ids_dav_o),
    .ids_ack_i(ids_ack_i), .ids_sofid_o(ids_sofid_o), .ids_ins_o(ids_ins_o),
    .ids_ferr_o(ids_ferr_o), .ids_pc_o(ids_pc_o), .hvec_pc_wr_i(hvec_pc_wr_i),
    .hvec_pc_din_i(hvec_pc_din_i), .exs_hpl_i(exs_hpl_i));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rsp_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Request rule: a free slot for every in-flight request plus one more,
  // fewer than OUTST in flight, no redirect, enabled and out of reset.
  function automatic bit m_reqvalid();
    return resetb_i && clk_en_i && !hvec_pc_wr_i && (cq.size() < OUTST)
        && (m_buf.size() + cq.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_buf.delete();
    cq.delete();
    m_kill = 0;
    m_jump = 1'b1;
    m_pc   = 32'h0;
  endtask

  task automatic model_edge();
    bit          rsp, acc;
    logic [31:0] a;
    ent_t        e;
    req_t        r;
    if (!resetb_i) begin
      model_reset();
    end else if (clk_en_i) begin
      rsp = irspvalid_i && (cq.size() > 0);
      acc = m_reqvalid() && ireqready_i;
      a = 32'h0;
      if (rsp) begin
        a = cq[0].addr;
        void'(cq.pop_front());
      end
      if (hvec_pc_wr_i) begin
        m_kill = cq.size();
        m_buf.delete();
        m_jump = 1'b1;
        m_pc   = hvec_pc_din_i;
      end else begin
        if (ids_ack_i && m_buf.size() > 0) void'(m_buf.pop_front());
        if (rsp) begin
          if (m_kill > 0) begin
            m_kill--;
          end else begin
            e.sofid = m_jump ? S_JUMP : S_RUN;
            e.ferr  = irsprerr_i;
            e.pc    = a;
            e.ins   = irspdata_i;
            m_buf.push_back(e);
            m_jump = 1'b0;
          end
        end
        if (acc) begin
          r.addr = m_pc;
          r.due  = cyc + lat;
          cq.push_back(r);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // One clock: update model at the edge, then drive cache response for next cycle.
  task automatic tick();
    @(posedge clk_i);
    cyc++;
    model_edge();
    #1;
    exs_hpl_i = cyc[1:0];
    if (resetb_i && !rsp_hold && cq.size() > 0 && cq[0].due <= cyc) begin
      irspvalid_i = 1'b1;
      irspdata_i  = rsp_data(cq[0].addr);
      irsprerr_i  = (cq[0].addr == err_addr);
    end else begin
      irspvalid_i = 1'b0;
      irspdata_i  = $urandom;
      irsprerr_i  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic apply_reset();
    resetb_i    = 1'b0;
    irspvalid_i = 1'b0;
    model_reset();
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    bit v;
    v = m_reqvalid();
    chk("ireqvalid", 32'(ireqvalid_o), 32'(v));
    if (v) chk("ireqaddr", ireqaddr_o, m_pc);
    chk("ireqhpl", 32'(ireqhpl_o), 32'(exs_hpl_i));
    chk("irspready", 32'(irspready_o), 32'd1);
    chk("ids_dav", 32'(ids_dav_o), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) begin
      chk("ids_pc", ids_pc_o, m_buf[0].pc);
      chk("ids_ins", ids_ins_o, m_buf[0].ins);
      chk("ids_ferr", 32'(ids_ferr_o), 32'(m_buf[0].ferr));
      chk("ids_sofid", 32'(ids_sofid_o), 32'(m_buf[0].sofid));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; lat = 0; rsp_hold = 1'b0;
    err_addr = 32'h8;
    clk_en_i = 1'b1; ireqready_i = 1'b1; ids_ack_i = 1'b0;
    hvec_pc_wr_i = 1'b0; hvec_pc_din_i = 32'h0; exs_hpl_i = 2'b00;
    irspvalid_i = 1'b0; irsprerr_i = 1'b0; irspdata_i = 32'h0;
    resetb_i = 1'b1;
    model_reset();
    #1 apply_reset();
    repeat (3) tick();
    chk("rst_dav", 32'(ids_dav_o), 32'd0);
    chk("rst_reqvalid", 32'(ireqvalid_o), 32'd0);
    resetb_i = 1'b1;

    // Fill with single-cycle responses; buffer holds 0x0,0x4,0x8,0xC.
    repeat (8) tick();
    chk("fill_reqvalid", 32'(ireqvalid_o), 32'd0);
    chk("fill_pc0", ids_pc_o, 32'h0);
    chk("fill_sofid0", 32'(ids_sofid_o), 32'(S_JUMP));
    chk("fill_ins0", ids_ins_o, 32'hC0DE_0000);
    ids_ack_i = 1'b1; tick(); ids_ack_i = 1'b0;
    chk("ack1_pc", ids_pc_o, 32'h4);
    chk("ack1_sofid", 32'(ids_sofid_o), 32'(S_RUN));
    chk("ack1_ferr", 32'(ids_ferr_o), 32'd0);
    chk("ack1_reqvalid", 32'(ireqvalid_o), 32'd1);
    ids_ack_i = 1'b1; tick(); ids_ack_i = 1'b0;
    chk("err_pc", ids_pc_o, 32'h8);
    chk("err_ferr", 32'(ids_ferr_o), 32'd1);
    chk("err_ins", ids_ins_o, 32'hC0DE_0008);
    ids_ack_i = 1'b1;
    repeat (10) tick();

    // Three-cycle response latency with acks every cycle.
    lat = 3;
    repeat (30) tick();

    // Two requests in flight (0x10, 0x14), then redirect to 0x200.
    ids_ack_i = 1'b0; lat = 6;
    hvec_pc_wr_i = 1'b1; hvec_pc_din_i = 32'h10; tick(); hvec_pc_wr_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cq.size() == 2 && cq[0].addr == 32'h10 && cq[1].addr == 32'h14) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_setup", 32'(found), 32'd1);
    hvec_pc_wr_i = 1'b1; hvec_pc_din_i = 32'h200; tick(); hvec_pc_wr_i = 1'b0;
    chk("t3_dav_after_redirect", 32'(ids_dav_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_buf.size() > 0) begin found = 1'b1; break; end
      tick();
    end
    chk("t3_delivered", 32'(found), 32'd1);
    chk("t3_pc", ids_pc_o, 32'h200);
    chk("t3_sofid", 32'(ids_sofid_o), 32'(S_JUMP));
    chk("t3_ins", ids_ins_o, 32'hC0DE_0200);

    // Redirect coinciding with a response and an ack, two in flight.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cq.size() == 2 && irspvalid_i && m_buf.size() > 0) begin found = 1'b1; break; end
      tick();
    end
    chk("t4_setup", 32'(found), 32'd1);
    ids_ack_i = 1'b1; hvec_pc_wr_i = 1'b1; hvec_pc_din_i = 32'h300;
    tick();
    ids_ack_i = 1'b0; hvec_pc_wr_i = 1'b0;
    chk("t4_dav_after_redirect", 32'(ids_dav_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_buf.size() > 0) begin found = 1'b1; break; end
      tick();
    end
    chk("t4_delivered", 32'(found), 32'd1);
    chk("t4_pc", ids_pc_o, 32'h300);
    chk("t4_sofid", 32'(ids_sofid_o), 32'(S_JUMP));

    // Ready toggling: address must hold while waiting.
    ids_ack_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ireqready_i = 1'($urandom_range(0, 1));
      tick();
    end
    ireqready_i = 1'b1;

    // Clock enable low for five cycles mid-stream, responses held off.
    lat = 2;
    repeat (10) tick();
    clk_en_i = 1'b0; rsp_hold = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_reqvalid", 32'(ireqvalid_o), 32'd0);
    end
    clk_en_i = 1'b1; rsp_hold = 1'b0;
    repeat (15) tick();

    // Reset mid-operation, then restart from the reset vector.
    apply_reset();
    repeat (2) tick();
    chk("rst2_dav", 32'(ids_dav_o), 32'd0);
    chk("rst2_reqvalid", 32'(ireqvalid_o), 32'd0);
    resetb_i = 1'b1; lat = 0; ids_ack_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_buf.size() > 0) begin found = 1'b1; break; end
      tick();
    end
    chk("rst2_delivered", 32'(found), 32'd1);
    chk("rst2_pc", ids_pc_o, 32'h0);
    chk("rst2_sofid", 32'(ids_sofid_o), 32'(S_JUMP));
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
